// File: rtl/processador_pkg.sv
// rtl/processador_pkg.sv - opcode, funct, ALUOp and ALU control constants for processador_core
package processador_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;
  localparam logic [5:0] FUNCT_NOR = 6'h27;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Main decoder outputs, grouped so the decoder can clear them in one go
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  // Second-level ALU decode; unknown funct codes and ALUOp 11 fall back to add
  function automatic logic [3:0] alu_control(input logic [1:0] alu_op, input logic [5:0] funct);
    logic [3:0] code;
    code = ALU_ADD;
    if (alu_op == ALUOP_SUB) begin
      code = ALU_SUB;
    end else if (alu_op == ALUOP_FUNCT) begin
      case (funct)
        FUNCT_ADD: code = ALU_ADD;
        FUNCT_SUB: code = ALU_SUB;
        FUNCT_AND: code = ALU_AND;
        FUNCT_OR:  code = ALU_OR;
        FUNCT_SLT: code = ALU_SLT;
        FUNCT_NOR: code = ALU_NOR;
        default:   code = ALU_ADD;
      endcase
    end
    return code;
  endfunction

endpackage

// File: rtl/processador_dmem.sv
// rtl/processador_dmem.sv - word-addressed data memory, zeroed at time 0 only, kept across reset
module processador_dmem #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  logic [31:0] memory [0:DEPTH-1] = '{default: '0};
  logic [7:0]  idx;
  logic        unused_addr;

  assign idx         = addr[9:2];
  assign unused_addr = ^{addr[31:10], addr[1:0]};

  // Stores commit on the same edge as the PC; a reset cycle drops the store
  always_ff @(posedge clk) begin
    if (!reset && we) memory[idx] <= wdata;
  end

  assign rdata = re ? memory[idx] : '0;

endmodule

// File: rtl/processador_regfile.sv
// rtl/processador_regfile.sv - 32x32 register bank, $0 hardwired to zero, no write forwarding
module processador_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  // Zero at time 0 so nothing undefined leaks out before the first reset
  logic [31:0] registers [0:31] = '{default: '0};

  // Reset clears every register and masks the write of that cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      registers[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : registers[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : registers[ra2];

endmodule

// File: rtl/processador_core.sv
// rtl/processador_core.sv - single-cycle MIPS subset core; PROCESSADOR_JUMP_EN enables the j instruction
module processador_core
  import processador_pkg::*;
#(
  parameter string IMEM_FILE  = "instrucoes.hex",
  parameter int    IMEM_DEPTH = 256,
  parameter int    DMEM_DEPTH = 256
) (
  input logic clk,
  input logic reset
);

  logic [31:0] pc = '0;
  logic [31:0] imem [0:IMEM_DEPTH-1];

  logic [31:0] instrucao;
  logic [5:0]  opcode;
  ctrl_t       ctrl;
  logic        RegDst, Branch, MemRead, MemtoReg, MemWrite, RegWrite, ALUSrc;
  logic [1:0]  ALUOp;
  logic [3:0]  controle;
  logic        Zero;
  logic [31:0] readData1, readData2, writeData, operando2, imediato, aluResult, memReadData;
  logic [4:0]  writeRegister;
  logic [31:0] pc_plus4, branch_target, pc_next;
  logic        unused_imm;
`ifdef PROCESSADOR_JUMP_EN
  logic        Jump;
`endif

  // ROM zeroed at time 0; program image is preloaded externally
  initial begin
    for (int i = 0; i < IMEM_DEPTH; i++) imem[i] = '0;
  end

  assign instrucao = imem[pc[9:2]];
  assign opcode    = instrucao[31:26];

  // Main decoder: unsupported opcodes leave every control low and act as NOPs
  always_comb begin
    ctrl = '0;
`ifdef PROCESSADOR_JUMP_EN
    Jump = 1'b0;
`endif
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALUOP_SUB;
      end
      OP_ADDI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
`ifdef PROCESSADOR_JUMP_EN
      OP_J: Jump = 1'b1;
`endif
      default: ;
    endcase
  end

  assign RegDst   = ctrl.reg_dst;
  assign ALUSrc   = ctrl.alu_src;
  assign MemtoReg = ctrl.mem_to_reg;
  assign RegWrite = ctrl.reg_write;
  assign MemRead  = ctrl.mem_read;
  assign MemWrite = ctrl.mem_write;
  assign Branch   = ctrl.branch;
  assign ALUOp    = ctrl.alu_op;
  assign controle = alu_control(ALUOp, instrucao[5:0]);

  assign writeRegister = RegDst ? instrucao[15:11] : instrucao[20:16];
  assign imediato      = {{16{instrucao[15]}}, instrucao[15:0]};
  assign operando2     = ALUSrc ? imediato : readData2;
  assign unused_imm    = ^imediato[31:30];

  processador_regfile reg_bank (
    .clk (clk),
    .reset (reset),
    .we  (RegWrite),
    .ra1 (instrucao[25:21]),
    .ra2 (instrucao[20:16]),
    .wa  (writeRegister),
    .wd  (writeData),
    .rd1 (readData1),
    .rd2 (readData2)
  );

  // ALU: wrapping arithmetic, slt is a signed compare
  always_comb begin
    case (controle)
      ALU_AND: aluResult = readData1 & operando2;
      ALU_OR:  aluResult = readData1 | operando2;
      ALU_SUB: aluResult = readData1 - operando2;
      ALU_SLT: aluResult = {31'b0, $signed(readData1) < $signed(operando2)};
      ALU_NOR: aluResult = ~(readData1 | operando2);
      default: aluResult = readData1 + operando2;
    endcase
  end

  assign Zero = (aluResult == 32'd0);

  processador_dmem #(.DEPTH(DMEM_DEPTH)) data_mem (
    .clk   (clk),
    .reset (reset),
    .we    (MemWrite),
    .re    (MemRead),
    .addr  (aluResult),
    .wdata (readData2),
    .rdata (memReadData)
  );

  assign writeData = MemtoReg ? memReadData : aluResult;

  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + {imediato[29:0], 2'b00};

  // Next-PC select: taken branch, optional jump, otherwise sequential
  always_comb begin
    pc_next = (Branch && Zero) ? branch_target : pc_plus4;
`ifdef PROCESSADOR_JUMP_EN
    if (Jump) pc_next = {pc_plus4[31:28], instrucao[25:0], 2'b00};
`endif
  end

  // PC register, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) pc <= '0;
    else       pc <= pc_next;
  end

endmodule

// File: tb/tb_processador_core.sv
// tb/tb_processador_core.sv - scoreboard bench for processador_core against an ISA-level model
module tb_processador_core;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  processador_core #(
    .IMEM_FILE  (""),
    .IMEM_DEPTH (256),
    .DMEM_DEPTH (256)
  ) dut (
    .clk   (clk),
    .reset (reset)
  );

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       instr;
    logic [8:0]        ctl;
    logic [3:0]        alu4;
    logic              chk_wd;
    logic [4:0]        wreg;
    logic [31:0]       wdata;
    logic [31:0]       mrd;
    logic              chk_zero;
    logic              zero;
    logic [31:0][31:0] regs;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] prog [256];
  logic [31:0] m_pc;
  logic [31:0] m_regs [32];
  logic [31:0] m_mem [256];
  logic [31:0] mem_snap [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic mem_check(input string name, input bit use_snap);
    int badi;
    logic [31:0] want;
    badi = -1;
    for (int i = 0; i < 256; i++) begin
      want = use_snap ? mem_snap[i] : m_mem[i];
      if (dut.data_mem.memory[i] !== want && badi < 0) badi = i;
    end
    total++;
    if (badi >= 0) begin
      bad++;
      want = use_snap ? mem_snap[badi] : m_mem[badi];
      $display("FAIL %s memory[%0d]: actual=%h required=%h", name, badi, dut.data_mem.memory[badi], want);
    end
  endtask

  task automatic wait_drain(input int limit);
    int t;
    t = 0;
    while (sb.size() != 0 && t < limit) begin
      @(posedge clk);
      t++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: actual=%0d entries left required=0", sb.size());
      sb.delete();
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rand_instr();
    int k, off;
    logic [4:0] rs, rt, rd;
    logic [5:0] fn;
    k  = int'($urandom_range(0, 13));
    rs = 5'($urandom_range(0, 15));
    rt = 5'($urandom_range(0, 15));
    rd = 5'($urandom_range(0, 15));
    case (k)
      0: fn = 6'h20;
      1: fn = 6'h22;
      2: fn = 6'h24;
      3: fn = 6'h25;
      4: fn = 6'h2A;
      5: fn = 6'h27;
      default: fn = 6'h03;
    endcase
    case (k)
      0, 1, 2, 3, 4, 5, 6: return rtype(rs, rt, rd, fn);
      7, 8: return itype(6'h08, rs, rt, 16'($urandom));
      9:  return itype(6'h23, 5'($urandom_range(0, 7)), rt, 16'($urandom_range(0, 1023)));
      10: return itype(6'h2B, 5'($urandom_range(0, 7)), rt, 16'($urandom_range(0, 1023)));
      11: begin
        off = int'($urandom_range(0, 12)) - 4;
        if (off == -1) off = 3;
        if (off < 0 && rs == rt) rt = rs + 5'd1;
        return itype(6'h04, rs, rt, 16'(off));
      end
      12: return {6'h3F, 26'($urandom)};
      default: return {6'h02, 18'd0, 8'($urandom)};
    endcase
  endfunction

  // Architectural step of the reference machine; returns what should be visible before the edge
  function automatic exp_t model_step();
    exp_t e;
    logic [31:0] ins, a, b, imm, r, npc, addr;
    logic [5:0]  op, fn;
    ins = prog[m_pc[9:2]];
    e = '0;
    e.pc = m_pc;
    e.instr = ins;
    for (int i = 0; i < 32; i++) e.regs[i] = m_regs[i];
    op   = ins[31:26];
    fn   = ins[5:0];
    imm  = {{16{ins[15]}}, ins[15:0]};
    a    = m_regs[ins[25:21]];
    b    = m_regs[ins[20:16]];
    npc  = m_pc + 32'd4;
    addr = a + imm;
    e.alu4 = 4'b0010;
    case (op)
      6'h00: begin
        e.ctl = 9'b1_0_0_1_0_0_0_10;
        case (fn)
          6'h22: begin r = a - b;    e.alu4 = 4'b0110; end
          6'h24: begin r = a & b;    e.alu4 = 4'b0000; end
          6'h25: begin r = a | b;    e.alu4 = 4'b0001; end
          6'h2A: begin r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; e.alu4 = 4'b0111; end
          6'h27: begin r = ~(a | b); e.alu4 = 4'b1100; end
          default: r = a + b;
        endcase
        e.chk_wd = 1'b1;
        e.wreg = ins[15:11];
        e.wdata = r;
        if (ins[15:11] != 5'd0) m_regs[ins[15:11]] = r;
      end
      6'h08: begin
        e.ctl = 9'b0_1_0_1_0_0_0_00;
        e.chk_wd = 1'b1;
        e.wreg = ins[20:16];
        e.wdata = addr;
        if (ins[20:16] != 5'd0) m_regs[ins[20:16]] = addr;
      end
      6'h23: begin
        e.ctl = 9'b0_1_1_1_1_0_0_00;
        e.mrd = m_mem[addr[9:2]];
        e.chk_wd = 1'b1;
        e.wreg = ins[20:16];
        e.wdata = e.mrd;
        if (ins[20:16] != 5'd0) m_regs[ins[20:16]] = e.mrd;
      end
      6'h2B: begin
        e.ctl = 9'b0_1_0_0_0_1_0_00;
        m_mem[addr[9:2]] = b;
      end
      6'h04: begin
        e.ctl = 9'b0_0_0_0_0_0_1_01;
        e.alu4 = 4'b0110;
        e.chk_zero = 1'b1;
        e.zero = (a == b);
        if (a == b) npc = npc + {imm[29:0], 2'b00};
      end
`ifdef PROCESSADOR_JUMP_EN
      6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
`endif
      default: ;
    endcase
    m_pc = npc;
    return e;
  endfunction

  task automatic model_reset();
    m_pc = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
  endtask

  initial begin : monitor
    exp_t e;
    int badi;
    forever begin
      @(negedge clk);
      if (!reset && sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc", dut.pc, e.pc);
        chk("instrucao", dut.instrucao, e.instr);
        chk("control", 32'({dut.RegDst, dut.ALUSrc, dut.MemtoReg, dut.RegWrite, dut.MemRead,
                            dut.MemWrite, dut.Branch, dut.ALUOp}), 32'(e.ctl));
        chk("controle", 32'(dut.controle), 32'(e.alu4));
        chk("memReadData", dut.memReadData, e.mrd);
        if (e.chk_wd) begin
          chk("writeRegister", 32'(dut.writeRegister), 32'(e.wreg));
          chk("writeData", dut.writeData, e.wdata);
        end
        if (e.chk_zero) chk("Zero", 32'(dut.Zero), 32'(e.zero));
        badi = -1;
        for (int i = 0; i < 32; i++)
          if (dut.reg_bank.registers[i] !== e.regs[i] && badi < 0) badi = i;
        total++;
        if (badi >= 0) begin
          bad++;
          $display("FAIL regs[%0d] at pc %h: actual=%h required=%h", badi, e.pc,
                   dut.reg_bank.registers[badi], e.regs[badi]);
        end
      end
    end
  end

  initial begin : stim
    #1;
    prog[0]  = itype(6'h08, 5'd0, 5'd1, 16'd5);
    prog[1]  = itype(6'h08, 5'd0, 5'd2, 16'hFFFD);
    prog[2]  = rtype(5'd1, 5'd2, 5'd3, 6'h20);
    prog[3]  = rtype(5'd2, 5'd1, 5'd4, 6'h22);
    prog[4]  = itype(6'h04, 5'd1, 5'd1, 16'd2);
    prog[5]  = itype(6'h08, 5'd0, 5'd13, 16'd1);
    prog[6]  = itype(6'h08, 5'd0, 5'd13, 16'd2);
    prog[7]  = itype(6'h04, 5'd1, 5'd2, 16'd2);
    prog[8]  = rtype(5'd2, 5'd1, 5'd5, 6'h2A);
    prog[9]  = rtype(5'd1, 5'd2, 5'd6, 6'h2A);
    prog[10] = itype(6'h08, 5'd0, 5'd8, 16'h00F0);
    prog[11] = itype(6'h08, 5'd0, 5'd9, 16'h003C);
    prog[12] = rtype(5'd8, 5'd9, 5'd10, 6'h24);
    prog[13] = rtype(5'd8, 5'd9, 5'd11, 6'h25);
    prog[14] = itype(6'h2B, 5'd0, 5'd1, 16'd8);
    prog[15] = itype(6'h23, 5'd0, 5'd7, 16'd8);
    prog[16] = itype(6'h08, 5'd0, 5'd0, 16'd7);
    prog[17] = 32'hFC21_1234;
    prog[18] = rtype(5'd8, 5'd9, 5'd12, 6'h27);
    prog[19] = {6'h02, 26'h40};
    for (int i = 20; i < 256; i++) prog[i] = rand_instr();
    for (int i = 0; i < 256; i++) dut.imem[i] = prog[i];

    chk("pc_time0", dut.pc, 32'h0);
    chk("reg5_time0", dut.reg_bank.registers[5], 32'h0);

    model_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    for (int n = 0; n < 400; n++) sb.push_back(model_step());

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    repeat (16) @(posedge clk);
    @(negedge clk);
    chk("dir_pc", dut.pc, 32'h48);
    chk("dir_add", dut.reg_bank.registers[3], 32'd2);
    chk("dir_sub", dut.reg_bank.registers[4], 32'hFFFF_FFF8);
    chk("dir_slt_true", dut.reg_bank.registers[5], 32'd1);
    chk("dir_slt_false", dut.reg_bank.registers[6], 32'd0);
    chk("dir_and", dut.reg_bank.registers[10], 32'h30);
    chk("dir_or", dut.reg_bank.registers[11], 32'hFC);
    chk("dir_lw", dut.reg_bank.registers[7], 32'd5);
    chk("dir_branch_skip", dut.reg_bank.registers[13], 32'd0);
    chk("dir_reg0", dut.reg_bank.registers[0], 32'd0);
    chk("dir_sw", dut.data_mem.memory[2], 32'd5);

    wait_drain(600);
    #1;
    mem_check("dmem_run1", 1'b0);

    reset = 1'b1;
    for (int i = 0; i < 256; i++) mem_snap[i] = m_mem[i];
    model_reset();
    for (int n = 0; n < 300; n++) sb.push_back(model_step());
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_pc", dut.pc, 32'h0);
    chk("reset_instrucao", dut.instrucao, prog[0]);
    for (int i = 0; i < 32; i++)
      chk($sformatf("reset_reg%0d", i), dut.reg_bank.registers[i], 32'h0);
    mem_check("dmem_kept_by_reset", 1'b1);

    wait_drain(500);
    #1;
    mem_check("dmem_run2", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
